// File: rtl/mem_stage_pkg.sv
// Shared uop types for the pipeline plus the memory-stage helper functions.
// The data-memory lane rules live here so that the stage and any unit test
// of the lane logic agree on one definition.
package Uop;

  typedef logic [31:0] w_t;
  typedef logic [29:0] waddr_t;
  typedef logic [4:0]  reg_t;
  typedef logic [3:0]  flags_t;

  typedef enum logic [1:0] {
    EX_NONE      = 2'd0,
    EX_ILLEGAL   = 2'd1,
    EX_MEM_ALIGN = 2'd2,
    EX_MEM_MISS  = 2'd3
  } ex_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_op_sz_t;

  typedef struct packed {
    logic       en;
    logic       we;
    mem_op_sz_t sz;
    logic       signExtend;
  } mem_op_t;

  // 2 + 5 + 32 + 32 + 5 + 1 + 4 = 81 bits
  typedef struct packed {
    ex_t     ex;
    reg_t    rd;
    w_t      rdVal;
    w_t      rs2Val;
    mem_op_t memOp;
    logic    flagsValid;
    flags_t  flags;
  } execute_t;

  // 2 + 5 + 32 + 1 + 4 = 44 bits
  typedef struct packed {
    ex_t    ex;
    reg_t   rd;
    w_t     rdVal;
    logic   flagsValid;
    flags_t flags;
  } memory_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUS  = 2'd1,
    MS_OUT  = 2'd2
  } mem_stage_state_t;

  localparam int EXECUTE_W = $bits(execute_t);
  localparam int MEMORY_W  = $bits(memory_t);

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] mem_be(mem_op_sz_t sz, logic [1:0] addrLo);
    logic [3:0] be;
    case (sz)
      MEM_B:   be = 4'b0001 << addrLo;
      MEM_H:   be = 4'b0011 << addrLo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Halfwords need an even address, words a multiple of four, bytes anything.
  function automatic logic mem_misaligned(mem_op_sz_t sz, logic [1:0] addrLo);
    logic bad;
    case (sz)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = addrLo[0];
      default: bad = (addrLo != 2'b00);
    endcase
    return bad;
  endfunction

  // Store data is replicated across every lane so the bus only needs byte enables.
  function automatic w_t mem_store_data(mem_op_sz_t sz, w_t rs2Val);
    w_t data;
    case (sz)
      MEM_B:   data = {4{rs2Val[7:0]}};
      MEM_H:   data = {2{rs2Val[15:0]}};
      default: data = rs2Val;
    endcase
    return data;
  endfunction

  // Pulls the addressed lane out of a load word and extends it to 32 bits.
  // Anything that is not an enabled load yields zero.
  function automatic w_t mem_load_extract(mem_op_t op, logic [1:0] addrLo, w_t data);
    logic [7:0]  b;
    logic [15:0] h;
    w_t          r;
    b = data[{addrLo, 3'b000} +: 8];
    h = data[{addrLo[1], 4'b0000} +: 16];
    case (op.sz)
      MEM_B:   r = op.signExtend ? {{24{b[7]}}, b} : {24'd0, b};
      MEM_H:   r = op.signExtend ? {{16{h[15]}}, h} : {16'd0, h};
      default: r = data;
    endcase
    if (!op.en || op.we) begin
      r = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Combinational byte-lane logic for the memory stage: byte enables,
// replicated store data and load lane extraction with sign/zero extension.
module mem_lane_align
  import Uop::*;
(
  input  mem_op_t    i_memOp,
  input  logic [1:0] i_addrLo,
  input  w_t         i_rs2Val,
  input  w_t         i_rdata,
  output logic [3:0] o_be,
  output w_t         o_wdata,
  output w_t         o_loadVal
);

  // Lane steering for both directions of the bus.
  always_comb begin
    o_be      = '0;
    o_wdata   = '0;
    o_loadVal = mem_load_extract(i_memOp, i_addrLo, i_rdata);
    if (i_memOp.en) begin
      o_be = mem_be(i_memOp.sz, i_addrLo);
    end
    if (i_memOp.en && i_memOp.we) begin
      o_wdata = mem_store_data(i_memOp.sz, i_rs2Val);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: accepts one execute uop per handshake, checks alignment,
// runs a single data-memory bus transaction for loads/stores and hands a
// memory uop to writeback. Non-memory and faulted uops pass straight through.
module mem_stage
  import Uop::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  execute_t in_uop,
  output logic     out_valid,
  input  logic     out_ready,
  output memory_t  out_uop,
  output logic     dmem_req,
  output logic     dmem_we,
  output waddr_t   dmem_addr,
  output logic [3:0] dmem_be,
  output w_t       dmem_wdata,
  input  logic     dmem_ack,
  input  w_t       dmem_rdata,
  input  logic     dmem_err
);

  mem_stage_state_t r_state;
  mem_stage_state_t w_nextState;

  logic       w_accept;
  logic       w_inMisaligned;
  logic       w_inNeedsBus;
  logic       w_ackOrErr;
  logic       w_busDone;

  mem_op_t    w_alignMemOp;
  logic [1:0] w_alignAddrLo;
  logic [3:0] w_be;
  w_t         w_wdata;
  w_t         w_loadVal;

  memory_t    w_inResult;
  memory_t    w_busResult;

  memory_t    r_outUop;
  logic [15:0] r_count;
  logic       r_flushed;
  w_t         r_addr;
  mem_op_t    r_memOp;
  reg_t       r_rd;
  logic       r_flagsValid;
  flags_t     r_flags;

  logic       r_dmemWe;
  waddr_t     r_dmemAddr;
  logic [3:0] r_dmemBe;
  w_t         r_dmemWdata;

  assign out_uop    = r_outUop;
  assign dmem_we    = r_dmemWe;
  assign dmem_addr  = r_dmemAddr;
  assign dmem_be    = r_dmemBe;
  assign dmem_wdata = r_dmemWdata;

  // Classify the incoming uop and the bus response of the current cycle.
  always_comb begin
    w_accept       = in_valid && in_ready;
    w_inMisaligned = mem_misaligned(in_uop.memOp.sz, in_uop.rdVal[1:0]);
    w_inNeedsBus   = (in_uop.ex == EX_NONE) && in_uop.memOp.en && !w_inMisaligned;
    w_ackOrErr     = dmem_ack || dmem_err;
    w_busDone      = w_ackOrErr || (r_count == 16'd1);
  end

  // The lane logic serves the incoming uop, except in BUS where it extracts the load.
  always_comb begin
    w_alignMemOp  = in_uop.memOp;
    w_alignAddrLo = in_uop.rdVal[1:0];
    if (r_state == MS_BUS) begin
      w_alignMemOp  = r_memOp;
      w_alignAddrLo = r_addr[1:0];
    end
  end

  mem_lane_align u_laneAlign (
    .i_memOp   (w_alignMemOp),
    .i_addrLo  (w_alignAddrLo),
    .i_rs2Val  (in_uop.rs2Val),
    .i_rdata   (dmem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_loadVal (w_loadVal)
  );

  // Result for uops that never touch the bus: pass-through or alignment fault.
  always_comb begin
    w_inResult            = '0;
    w_inResult.ex         = in_uop.ex;
    w_inResult.rd         = in_uop.rd;
    w_inResult.rdVal      = in_uop.rdVal;
    w_inResult.flagsValid = in_uop.flagsValid;
    w_inResult.flags      = in_uop.flags;
    if ((in_uop.ex == EX_NONE) && in_uop.memOp.en && w_inMisaligned) begin
      w_inResult.ex = EX_MEM_ALIGN;
    end
  end

  // Result when the bus completes; err beats ack and timeout counts as a miss.
  always_comb begin
    w_busResult            = '0;
    w_busResult.rd         = r_rd;
    w_busResult.flagsValid = r_flagsValid;
    w_busResult.flags      = r_flags;
    w_busResult.rdVal      = r_addr;
    if (dmem_ack && !dmem_err) begin
      w_busResult.ex = EX_NONE;
      if (!r_memOp.we) begin
        w_busResult.rdVal = w_loadVal;
      end
    end else begin
      w_busResult.ex = EX_MEM_MISS;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MS_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a flushed bus transaction still runs to completion.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      MS_IDLE: begin
        if (w_accept) begin
          w_nextState = w_inNeedsBus ? MS_BUS : MS_OUT;
        end
      end
      MS_BUS: begin
        if (w_busDone) begin
          w_nextState = (r_flushed || flush) ? MS_IDLE : MS_OUT;
        end
      end
      MS_OUT: begin
        if (flush) begin
          w_nextState = MS_IDLE;
        end else if (out_ready) begin
          if (w_accept) begin
            w_nextState = w_inNeedsBus ? MS_BUS : MS_OUT;
          end else begin
            w_nextState = MS_IDLE;
          end
        end
      end
      default: w_nextState = MS_IDLE;
    endcase
  end

  // State-decoded outputs: handshake readiness, result valid and bus request.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dmem_req  = 1'b0;
    case (r_state)
      MS_IDLE: in_ready = !flush;
      MS_BUS:  dmem_req = 1'b1;
      MS_OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !flush;
      end
      default: ;
    endcase
  end

  // Uop capture, bus request fields, timeout counter and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outUop     <= '0;
      r_count      <= '0;
      r_flushed    <= 1'b0;
      r_addr       <= '0;
      r_memOp      <= '0;
      r_rd         <= '0;
      r_flagsValid <= 1'b0;
      r_flags      <= '0;
      r_dmemWe     <= 1'b0;
      r_dmemAddr   <= '0;
      r_dmemBe     <= '0;
      r_dmemWdata  <= '0;
    end else if (w_accept) begin
      r_rd         <= in_uop.rd;
      r_flagsValid <= in_uop.flagsValid;
      r_flags      <= in_uop.flags;
      r_addr       <= in_uop.rdVal;
      r_memOp      <= in_uop.memOp;
      r_flushed    <= 1'b0;
      if (w_inNeedsBus) begin
        r_dmemAddr  <= in_uop.rdVal[31:2];
        r_dmemBe    <= w_be;
        r_dmemWe    <= in_uop.memOp.we;
        r_dmemWdata <= w_wdata;
        r_count     <= 16'(TIMEOUT_CYCLES);
      end else begin
        r_outUop <= w_inResult;
      end
    end else if (r_state == MS_BUS) begin
      if (flush) begin
        r_flushed <= 1'b1;
      end
      if (!w_ackOrErr) begin
        r_count <= r_count - 16'd1;
      end
      if (w_busDone) begin
        r_outUop <= w_busResult;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// uops, each compared against a behavioural model of the stage.
module tb_mem_stage;
  import Uop::*;

  localparam int TIMEOUT = 4;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  execute_t   in_uop;
  logic       out_valid;
  logic       out_ready;
  memory_t    out_uop;
  logic       dmem_req;
  logic       dmem_we;
  waddr_t     dmem_addr;
  logic [3:0] dmem_be;
  w_t         dmem_wdata;
  logic       dmem_ack;
  w_t         dmem_rdata;
  logic       dmem_err;

  int compareCount  = 0;
  int mismatchCount = 0;

  mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_uop     (in_uop),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_uop    (out_uop),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .dmem_err   (dmem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic execute_t mkUop(ex_t ex, logic [4:0] rd, w_t rdVal, w_t rs2,
                                     logic en, logic we, mem_op_sz_t sz, logic sx,
                                     logic fv, logic [3:0] flags);
    execute_t u;
    u.ex               = ex;
    u.rd               = rd;
    u.rdVal            = rdVal;
    u.rs2Val           = rs2;
    u.memOp.en         = en;
    u.memOp.we         = we;
    u.memOp.sz         = sz;
    u.memOp.signExtend = sx;
    u.flagsValid       = fv;
    u.flags            = flags;
    return u;
  endfunction

  function automatic int sizeBytes(mem_op_sz_t sz);
    return (sz == MEM_B) ? 1 : (sz == MEM_H) ? 2 : 4;
  endfunction

  // Expected bus fields, from access size and byte offset arithmetic.
  function automatic void busModel(input execute_t u, output logic [3:0] beExp, output w_t wdExp);
    int    size;
    int    a;
    longint rs2;
    size  = sizeBytes(u.memOp.sz);
    a     = int'(u.rdVal % 4);
    beExp = 4'((((1 << size) - 1) << a) & 15);
    rs2   = longint'(u.rs2Val);
    if (size == 1)      wdExp = w_t'((rs2 % 256) * 64'h0101_0101);
    else if (size == 2) wdExp = w_t'((rs2 % 65536) * 64'h0001_0001);
    else                wdExp = u.rs2Val;
  endfunction

  // Expected stage result. resp: 0 ack, 1 err, 2 ack+err, 3 silence.
  function automatic void modelResult(input execute_t u, input int resp, input int waitCycles,
                                      input w_t rdata, output memory_t exp, output bit busExp,
                                      output int reqExp, output bit rdValKnown);
    int     size;
    int     a;
    bit     timedOut;
    longint lane;
    longint span;
    exp            = '0;
    exp.ex         = u.ex;
    exp.rd         = u.rd;
    exp.rdVal      = u.rdVal;
    exp.flagsValid = u.flagsValid;
    exp.flags      = u.flags;
    busExp         = 1'b0;
    reqExp         = 0;
    rdValKnown     = 1'b1;
    if (u.ex != EX_NONE || !u.memOp.en) return;
    size = sizeBytes(u.memOp.sz);
    a    = int'(u.rdVal % 4);
    if (a % size != 0) begin
      exp.ex = EX_MEM_ALIGN;
      return;
    end
    busExp   = 1'b1;
    timedOut = (resp == 3) || (waitCycles >= TIMEOUT);
    reqExp   = timedOut ? TIMEOUT : waitCycles + 1;
    if (timedOut || resp == 1 || resp == 2) begin
      exp.ex     = EX_MEM_MISS;
      rdValKnown = 1'b0;
      return;
    end
    if (!u.memOp.we) begin
      span = longint'(1) << (8 * size);
      lane = (longint'(rdata) >> (8 * a)) % span;
      if (u.memOp.signExtend && lane >= span / 2) lane = lane - span;
      exp.rdVal = w_t'(lane);
    end
  endfunction

  // Present a uop and wait (bounded) for the accepting edge.
  task automatic applyStimulus(input execute_t u);
    int n;
    in_valid = 1'b1;
    in_uop   = u;
    n        = 0;
    #1;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) checkOutput("acceptTimeout", 64'(n), 64'd0);
    step();
    in_valid = 1'b0;
  endtask

  // One complete transaction from acceptance to writeback handoff.
  task automatic doMemTxn(input string tag, input execute_t u, input int resp,
                          input int waitCycles, input w_t rdata);
    memory_t    exp;
    bit         busExp;
    bit         known;
    int         reqExp;
    int         reqCount;
    logic [3:0] beExp;
    w_t         wdExp;
    modelResult(u, resp, waitCycles, rdata, exp, busExp, reqExp, known);
    busModel(u, beExp, wdExp);
    out_ready = 1'b1;
    applyStimulus(u);
    reqCount = 0;
    while (dmem_req === 1'b1 && reqCount < 100) begin
      reqCount++;
      checkOutput({tag, " addr"}, 64'(dmem_addr), 64'(u.rdVal[31:2]));
      checkOutput({tag, " be"}, 64'(dmem_be), 64'(beExp));
      checkOutput({tag, " we"}, 64'(dmem_we), 64'(u.memOp.we));
      if (u.memOp.we) checkOutput({tag, " wdata"}, 64'(dmem_wdata), 64'(wdExp));
      if (resp != 3 && reqCount == waitCycles + 1) begin
        dmem_ack   = (resp == 0 || resp == 2);
        dmem_err   = (resp == 1 || resp == 2);
        dmem_rdata = rdata;
      end
      step();
      dmem_ack   = 1'b0;
      dmem_err   = 1'b0;
      dmem_rdata = $urandom;
    end
    checkOutput({tag, " reqCycles"}, 64'(reqCount), 64'(reqExp));
    checkOutput({tag, " outValid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, " ex"}, 64'(out_uop.ex), 64'(exp.ex));
    checkOutput({tag, " rd"}, 64'(out_uop.rd), 64'(exp.rd));
    checkOutput({tag, " flags"}, 64'({out_uop.flagsValid, out_uop.flags}),
                64'({exp.flagsValid, exp.flags}));
    if (known) checkOutput({tag, " rdVal"}, 64'(out_uop.rdVal), 64'(exp.rdVal));
    step();
    checkOutput({tag, " drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    execute_t   u;
    execute_t   uA;
    execute_t   uB;
    execute_t   uC;
    memory_t    expA;
    memory_t    expB;
    memory_t    expC;
    bit         dummyBus;
    bit         dummyKnown;
    int         dummyReq;
    int         sel;
    int         respSel;
    int         resp;
    int         waitCycles;

    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_uop     = '0;
    out_ready  = 1'b1;
    dmem_ack   = 1'b0;
    dmem_err   = 1'b0;
    dmem_rdata = '0;

    // Reset state
    #3;
    checkOutput("reset outValid", 64'(out_valid), 64'd0);
    checkOutput("reset outUop", 64'(out_uop), 64'd0);
    checkOutput("reset req", 64'(dmem_req), 64'd0);
    checkOutput("reset we", 64'(dmem_we), 64'd0);
    checkOutput("reset be", 64'(dmem_be), 64'd0);
    checkOutput("reset addr", 64'(dmem_addr), 64'd0);
    checkOutput("reset wdata", 64'(dmem_wdata), 64'd0);
    checkOutput("reset inReady", 64'(in_ready), 64'd1);
    #9 rst_n = 1'b1;
    step();

    $display("[TB] directed: LDB signed");
    u = mkUop(EX_NONE, 5'd3, 32'h0000_1003, 32'h0, 1'b1, 1'b0, MEM_B, 1'b1, 1'b1, 4'h5);
    doMemTxn("ldbSigned", u, 0, 2, 32'h80FF_0000);

    $display("[TB] directed: STH");
    u = mkUop(EX_NONE, 5'd4, 32'h0000_2002, 32'h1234_ABCD, 1'b1, 1'b1, MEM_H, 1'b0, 1'b0, 4'h0);
    doMemTxn("sth", u, 0, 0, 32'h0);

    $display("[TB] directed: LDW misaligned");
    u = mkUop(EX_NONE, 5'd5, 32'h0000_3001, 32'h0, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 4'h0);
    doMemTxn("ldwAlign", u, 0, 0, 32'h0);

    $display("[TB] directed: timeout and ack+err");
    u = mkUop(EX_NONE, 5'd6, 32'h0000_4000, 32'h0, 1'b1, 1'b0, MEM_W, 1'b0, 1'b1, 4'h9);
    doMemTxn("timeout", u, 3, 0, 32'h0);
    doMemTxn("lastCycleAck", u, 0, TIMEOUT - 1, 32'hCAFE_F00D);
    u = mkUop(EX_NONE, 5'd7, 32'h0000_5004, 32'h0, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 4'h0);
    doMemTxn("ackErr", u, 2, 1, 32'h1111_2222);

    $display("[TB] directed: back-pressure and back-to-back");
    uA = mkUop(EX_NONE, 5'd10, 32'hAAAA_0001, 32'h0, 1'b0, 1'b0, MEM_W, 1'b0, 1'b1, 4'h1);
    uB = mkUop(EX_NONE, 5'd11, 32'hBBBB_0002, 32'h0, 1'b0, 1'b0, MEM_W, 1'b0, 1'b0, 4'h2);
    uC = mkUop(EX_ILLEGAL, 5'd12, 32'hCCCC_0003, 32'h0, 1'b1, 1'b0, MEM_W, 1'b0, 1'b1, 4'h3);
    modelResult(uA, 0, 0, 32'h0, expA, dummyBus, dummyReq, dummyKnown);
    modelResult(uB, 0, 0, 32'h0, expB, dummyBus, dummyReq, dummyKnown);
    modelResult(uC, 0, 0, 32'h0, expC, dummyBus, dummyReq, dummyKnown);
    out_ready = 1'b0;
    applyStimulus(uA);
    in_valid = 1'b1;
    in_uop   = uB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("stall%0d inReady", i), 64'(in_ready), 64'd0);
      checkOutput($sformatf("stall%0d outValid", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("stall%0d outUop", i), 64'(out_uop), 64'(expA));
      step();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release inReady", 64'(in_ready), 64'd1);
    step();
    in_uop = uC;
    checkOutput("b2b first valid", 64'(out_valid), 64'd1);
    checkOutput("b2b first uop", 64'(out_uop), 64'(expB));
    step();
    in_valid = 1'b0;
    checkOutput("b2b second valid", 64'(out_valid), 64'd1);
    checkOutput("b2b second uop", 64'(out_uop), 64'(expC));
    step();
    checkOutput("b2b idle", 64'(out_valid), 64'd0);

    $display("[TB] directed: flush in BUS");
    u = mkUop(EX_NONE, 5'd13, 32'h0000_6000, 32'h0, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 4'h0);
    applyStimulus(u);
    checkOutput("flushBus req", 64'(dmem_req), 64'd1);
    flush = 1'b1;
    #1;
    checkOutput("flushBus inReady", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    checkOutput("flushBus reqHeld", 64'(dmem_req), 64'd1);
    step();
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    checkOutput("flushBus reqDropped", 64'(dmem_req), 64'd0);
    checkOutput("flushBus noValid", 64'(out_valid), 64'd0);
    step();
    checkOutput("flushBus stillNoValid", 64'(out_valid), 64'd0);
    checkOutput("flushBus idle", 64'(in_ready), 64'd1);

    $display("[TB] directed: flush in OUT");
    out_ready = 1'b0;
    applyStimulus(uA);
    checkOutput("flushOut valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("flushOut cleared", 64'(out_valid), 64'd0);
    out_ready = 1'b1;

    $display("[TB] directed: reset mid-BUS");
    u = mkUop(EX_NONE, 5'd14, 32'h0000_7000, 32'h0, 1'b1, 1'b0, MEM_W, 1'b0, 1'b0, 4'h0);
    applyStimulus(u);
    checkOutput("rstBus req", 64'(dmem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstBus reqDropped", 64'(dmem_req), 64'd0);
    checkOutput("rstBus be", 64'(dmem_be), 64'd0);
    #3 rst_n = 1'b1;
    step();

    $display("[TB] random uops");
    for (int i = 0; i < 40; i++) begin
      sel     = $urandom_range(0, 9);
      respSel = $urandom_range(0, 9);
      resp    = (respSel < 6) ? 0 : (respSel < 7) ? 1 : (respSel < 8) ? 2 : 3;
      waitCycles = $urandom_range(0, 5);
      u = mkUop((sel == 0) ? EX_ILLEGAL : EX_NONE, 5'($urandom), $urandom, $urandom,
                (sel != 1), 1'($urandom), mem_op_sz_t'($urandom_range(0, 2)),
                1'($urandom), 1'($urandom), 4'($urandom));
      doMemTxn($sformatf("rnd%0d", i), u, resp, waitCycles, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the RISC pipeline, and the responder end of the memory-op encoding that decode/execute produce.
- Accepts one `Uop::execute_t` per handshake, checks alignment and drives the data-memory bus for loads/stores.
- Performs byte-lane steering and sign/zero extension, then emits a `Uop::memory_t` to writeback.
- Non-memory and already-faulted uops pass through with one cycle of latency.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for ack/err before declaring EX_MEM_MISS; range 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard the in-flight uop and the output register
- in_valid  in  1  execute_t on in_uop is valid
- in_ready  out  1  stage can accept this cycle
- in_uop  in  81  `Uop::execute_t`
- out_valid  out  1  out_uop is valid
- out_ready  in  1  writeback accepts out_uop
- out_uop  out  44  `Uop::memory_t`
- dmem_req  out  1  bus request, held until ack, err or timeout
- dmem_we  out  1  1 = store
- dmem_addr  out  30  word address (`waddr_t`), taken from rdVal[31:2]
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  store data, replicated across lanes
- dmem_ack  in  1  bus completes; dmem_rdata is valid this cycle
- dmem_rdata  in  32  load word
- dmem_err  in  1  bus error, completes the request

Behaviour:
- Reset: state IDLE; out_valid=0; out_uop=0; dmem_req=0; dmem_we=0; dmem_be=0; dmem_addr=0; dmem_wdata=0; timeout counter=0. Reset mid-bus-transaction drops dmem_req immediately.
- FSM states:
  - IDLE: no uop held.
  - BUS: dmem_req asserted.
  - OUT: out_valid=1.
- Acceptance: in_ready = (state==IDLE || (state==OUT && out_ready)) && !flush. A transfer occurs when in_valid && in_ready.
- Pass-through: applies when in_uop.ex != EX_NONE or memOp.en==0.
  - Next cycle: out_valid=1, state OUT.
  - out_uop = {ex, rd, rdVal, flagsValid, flags}.
- Alignment check (memOp.en=1, ex==EX_NONE):
  - H requires addr[0]==0; W requires addr[1:0]==0; B always passes.
  - Fail: no bus request; next cycle out_valid=1 with ex=EX_MEM_ALIGN, rd and rdVal passed through.
- Bus start: the cycle after acceptance, dmem_req=1 and state BUS; the counter is loaded with TIMEOUT_CYCLES.
- Byte enables:
  - B: be = 4'b0001 << addr[1:0].
  - H: be = 4'b0011 << addr[1:0].
  - W: be = 4'b1111.
- Store data: B uses {4{rs2Val[7:0]}}; H uses {2{rs2Val[15:0]}}; W uses rs2Val.
- Bus stability: dmem_addr, dmem_be, dmem_we and dmem_wdata stay stable while dmem_req=1.
- BUS exit conditions:
  - dmem_ack: drop req, state OUT, out_valid=1 next cycle.
    - Load: rdVal = extracted lane; B takes rdata[8*addr+:8], H takes rdata[16*addr[1]+:16]; sign-extended if signExtend, else zero-extended.
    - Store: rdVal = address unchanged.
    - ex=EX_NONE in both cases.
  - dmem_err: same timing as ack, with ex=EX_MEM_MISS.
  - Counter reaching 0 without ack/err: drop req; result ex=EX_MEM_MISS.
  - Simultaneous ack and err: err wins.
  - Counter decrements each BUS cycle without ack/err. Ack on the final counted cycle counts as ack, not timeout.
- Flags/rd: flagsValid, flags and rd are always copied from in_uop. On EX_MEM_MISS and EX_MEM_ALIGN, rd is kept; writeback suppresses it.
- OUT state:
  - out_uop is held stable while out_valid && !out_ready.
  - On out_ready with a new input transfer: back-to-back, no bubble.
  - On out_ready without a new transfer: go to IDLE.
- flush:
  - Clears out_valid (OUT→IDLE) the next cycle.
  - In BUS: dmem_req stays asserted until ack/err/timeout, then the result is discarded and state returns to IDLE. Requests are never retracted mid-flight.
  - in_ready=0 during flush.

Decomposition:
- Package Uop gains:
  - `mem_stage_state_t` enum {MS_IDLE, MS_BUS, MS_OUT}.
  - Functions `mem_be(mem_op_sz_t, logic[1:0])`, `mem_misaligned(mem_op_sz_t, logic[1:0])` and `mem_load_extract(mem_op_t, logic[1:0], w_t)`.
- One combinational sub-module, mem_lane_align: be, wdata and load-extract logic, separately unit-testable.
- FSM, counter and registers live in mem_stage.

Test Plan:
- LDB signed: rdVal=0x1003, rdata=0x80FF_0000, ack after 2 wait cycles → req asserted 3 cycles; out rdVal=0xFFFF_FF80, be=4'b1000, ex=EX_NONE.
- STH: rdVal=0x2002, rs2Val=0x1234_ABCD → dmem_we=1, be=4'b1100, wdata=0xABCD_ABCD, addr=0x800; out ex=EX_NONE.
- LDW misaligned: rdVal=0x3001 → dmem_req never asserted; out_valid next cycle with ex=EX_MEM_ALIGN.
- Timeout: TIMEOUT_CYCLES=4, no ack → req high 4 cycles then low; out ex=EX_MEM_MISS. Separately, ack+err together → EX_MEM_MISS.
- Back-pressure/back-to-back: out_ready=0 for 3 cycles → out_uop stable, in_ready=0. Then out_ready=1 with two queued ALU uops → both delivered on consecutive cycles.
- Flush in BUS: flush asserted, ack 2 cycles later → no out_valid, state IDLE; rst_n low mid-BUS → dmem_req=0 immediately.
